// File: rtl/inst_rom_responder.sv
// Instruction-fetch memory responder: word array with a loader write port and a
// programmable-latency fetch FSM. Optional misaligned-fetch trap via MISALIGN_TRAP_EN.
module inst_rom_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce,
  input  logic [31:0] rom_addr,
  output logic [31:0] rom_data,
  output logic        stall_req,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        misalign
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d;
  logic [31:0]     addr_p0, addr_d;
  logic [31:0]     data_d;
  logic            mis_d;
  logic            bad_align;
  logic [ADDR_W-1:0] rd_idx;
  logic            rd_hit;
  logic [31:0]     fetch_word;
  logic            unused_bits;

  logic [31:0] mem [DEPTH];

  function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
    return a[ADDR_W+1:2];
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return (a >> (ADDR_W + 2)) == 32'd0;
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign bad_align = (rom_addr[1:0] != 2'b00);
`else
  assign bad_align = 1'b0;
`endif

  // byte-offset bits carry no information in the word-indexed array
  assign unused_bits = ^{rom_addr[1:0], load_addr[1:0], addr_p0[1:0]};

  always_ff @(posedge clk) begin
    if (load_we && in_range(load_addr))
      mem[word_idx(load_addr)] <= load_data;
  end

  // Write-first: a load landing on the completing edge bypasses the array
  assign rd_idx     = word_idx(addr_p0);
  assign rd_hit     = load_we && in_range(load_addr) && (word_idx(load_addr) == rd_idx);
  assign fetch_word = !in_range(addr_p0) ? 32'd0 :
                      rd_hit             ? load_data : mem[rd_idx];

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    addr_d    = addr_p0;
    data_d    = rom_data;
    mis_d     = misalign;
    stall_req = 1'b0;
    case (state)
      IDLE: begin
        data_d = 32'd0;
        mis_d  = 1'b0;
        if (rom_ce) begin
          if (bad_align) begin
            mis_d = 1'b1;
          end else begin
            addr_d    = rom_addr;
            cnt_d     = CNT_INIT;
            stall_req = 1'b1;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        stall_req = 1'b1;
        if (!rom_ce) begin
          data_d  = 32'd0;
          state_d = IDLE;
        end else if (cnt == 4'd0) begin
          data_d  = fetch_word;
          state_d = VALID;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      VALID: begin
        if (!rom_ce) begin
          data_d  = 32'd0;
          mis_d   = 1'b0;
          state_d = IDLE;
        end else if (bad_align) begin
          data_d  = 32'd0;
          mis_d   = 1'b1;
          state_d = IDLE;
        end else if (rom_addr[31:2] != addr_p0[31:2]) begin
          addr_d    = rom_addr;
          cnt_d     = CNT_INIT;
          mis_d     = 1'b0;
          stall_req = 1'b1;
          state_d   = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) stall_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      addr_p0  <= 32'd0;
      rom_data <= 32'd0;
      misalign <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      addr_p0  <= addr_d;
      rom_data <= data_d;
      misalign <= mis_d;
    end
  end

endmodule

// File: tb/tb_inst_rom_responder.sv
// Directed + randomized bench for inst_rom_responder against a word-array reference model.
module tb_inst_rom_responder;

  localparam int AW = 10;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = '0;
  logic [31:0] rom_data;
  logic        stall_req;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        misalign;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [1 << AW];

  inst_rom_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data),
    .stall_req(stall_req), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk32(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input logic obs, input logic exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> (AW + 2)) == 32'd0;
  endfunction

  function automatic logic [31:0] expected_word(input logic [31:0] a);
    return in_rng(a) ? model[a[AW+1:2]] : 32'd0;
  endfunction

  task automatic mdl_write(input logic [31:0] wa, input logic [31:0] wd);
    if (in_rng(wa)) model[wa[AW+1:2]] = wd;
  endtask

  // Called #1 after a rising edge with the DUT idle or holding a different word.
  task automatic fetch(input logic [31:0] a, input bit rnd_wr, input bit force_col,
                       input logic [31:0] col_data, input string tag);
    logic [31:0] wa, wd;
    bit we;
    int r;
    rom_ce = 1'b1;
    rom_addr = a;
    #1;
    chk1(stall_req, 1'b1, {tag, ":req_stall"});
    @(posedge clk); #1;
    chk1(stall_req, 1'b1, {tag, ":wait_stall"});
    for (int k = 1; k <= WC; k++) begin
      we = 1'b0; wa = '0; wd = '0;
      if (k == WC && force_col) begin
        we = 1'b1; wa = a; wd = col_data;
      end else if (rnd_wr && $urandom_range(1, 0) == 1) begin
        we = 1'b1;
        wd = $urandom;
        if ($urandom_range(1, 0) == 1) wa = a;
        else begin
          r = $urandom_range((1 << AW) - 1, 0);
          wa = 32'(r) << 2;
          if ($urandom_range(7, 0) == 0) wa = wa | 32'h0010_0000;
        end
      end
      load_we = we; load_addr = wa; load_data = wd;
      @(posedge clk);
      if (we) mdl_write(wa, wd);
      #1;
      load_we = 1'b0;
      if (k < WC) chk1(stall_req, 1'b1, {tag, ":wait_stall"});
    end
    chk1(stall_req, 1'b0, {tag, ":done_stall"});
    chk32(rom_data, expected_word(a), {tag, ":data"});
    chk1(misalign, 1'b0, {tag, ":misalign"});
  endtask

  task automatic drop_ce(input string tag);
    rom_ce = 1'b0;
    @(posedge clk); #1;
    chk32(rom_data, 32'd0, {tag, ":idle_data"});
    chk1(stall_req, 1'b0, {tag, ":idle_stall"});
  endtask

  initial begin
    logic [31:0] a, last_a, held;
    int r;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk32(rom_data, 32'd0, "rst:data");
    chk1(stall_req, 1'b0, "rst:stall");
    chk1(misalign, 1'b0, "rst:misalign");
    rst = 1'b0;

    // boot load of the whole array
    for (int i = 0; i < (1 << AW); i++) begin
      load_we = 1'b1; load_addr = 32'(i) << 2; load_data = $urandom;
      @(posedge clk);
      mdl_write(load_addr, load_data);
      #1;
    end
    load_we = 1'b1; load_addr = 32'h0; load_data = 32'h3401_0020;
    @(posedge clk); mdl_write(load_addr, load_data); #1;
    load_we = 1'b0;
    chk1(stall_req, 1'b0, "load:no_stall");

    fetch(32'h0, 1'b0, 1'b0, 32'h0, "f0");
    chk32(rom_data, 32'h3401_0020, "f0:const");

    // hold in VALID with the same address
    held = rom_data;
    repeat (3) begin
      @(posedge clk); #1;
      chk1(stall_req, 1'b0, "hold:stall");
      chk32(rom_data, held, "hold:data");
    end

    fetch(32'h4, 1'b0, 1'b0, 32'h0, "f4");
    fetch(32'h8, 1'b0, 1'b0, 32'h0, "f8");
    drop_ce("drop8");
    fetch(32'h8, 1'b0, 1'b1, 32'hDEAD_BEEF, "col8");
    chk32(rom_data, 32'hDEAD_BEEF, "col8:const");

    // abort a fetch by dropping rom_ce during WAIT
    rom_ce = 1'b1; rom_addr = 32'hC;
    @(posedge clk); #1;
    rom_ce = 1'b0;
    @(posedge clk); #1;
    chk32(rom_data, 32'd0, "abort:data");
    chk1(stall_req, 1'b0, "abort:stall");

    // reset in the middle of WAIT
    rom_ce = 1'b1; rom_addr = 32'h10;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rom_ce = 1'b0;
    chk32(rom_data, 32'd0, "rstwait:data");
    #1;
    chk1(stall_req, 1'b0, "rstwait:stall");
    @(posedge clk); #1;
    fetch(32'h10, 1'b0, 1'b0, 32'h0, "postrst");

    fetch(32'h0004_0000, 1'b0, 1'b0, 32'h0, "oor");
    chk32(rom_data, 32'd0, "oor:zero");

`ifdef MISALIGN_TRAP_EN
    drop_ce("premis");
    rom_ce = 1'b1; rom_addr = 32'h6;
    #1;
    chk1(stall_req, 1'b0, "mis6:stall_req");
    @(posedge clk); #1;
    chk1(misalign, 1'b1, "mis6:flag");
    chk32(rom_data, 32'd0, "mis6:data");
    chk1(stall_req, 1'b0, "mis6:stall");
    fetch(32'h4, 1'b0, 1'b0, 32'h0, "mis4");
`else
    fetch(32'h5, 1'b0, 1'b0, 32'h0, "lowbits5");
`endif

    // randomized fetches with concurrent loads
    last_a = rom_addr;
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range((1 << AW) - 1, 0);
      a = 32'(r) << 2;
      if ($urandom_range(7, 0) == 0) a = a | 32'h0100_0000;
      if (rom_ce && a[31:2] == last_a[31:2]) a = a ^ 32'h4;
      fetch(a, 1'b1, ($urandom_range(3, 0) == 0), $urandom, "rnd");
      last_a = a;
      if ($urandom_range(2, 0) == 0) drop_ce("rnd_drop");
    end

    rom_ce = 1'b0;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
